branch_resolve_queue: RTL
=========================

// Module: branch_resolve_queue
// PURPOSE
//   Tracks in-flight conditional branches between prediction and resolution.
//   Queues each prediction from the 2-bit saturating predictor in program order.
//   Pairs the oldest entry with the execute-stage outcome and drives the
//   predictor's result/taken training inputs.
//   Flags mispredictions, flushes wrong-path entries and keeps hit/miss statistics.
// PARAMETERS
//   DEPTH  4   queue entries; power of two, 2..16
//   CNT_W  16  width of the hit/miss statistics counters
// PORTS
//   clk           in   1         rising-edge clock
//   rst           in   1         asynchronous, active-high reset
//   enable        in   1         global enable; low = no push, no pop, no pulses
//   pred_valid    in   1         a prediction is being issued this cycle
//   pred_bit      in   1         predicted direction (1 = taken)
//   resolve_valid in   1         execute stage resolved the oldest branch
//   resolve_taken in   1         actual direction of that branch
//   upd_result    out  1         one-cycle pulse; train the predictor (its "result")
//   upd_taken     out  1         direction to train with (its "taken")
//   mispredict    out  1         one-cycle pulse; oldest prediction was wrong
//   full          out  1         count == DEPTH
//   empty         out  1         count == 0
//   count         out  $clog2(DEPTH)+1  occupied entries
//   overflow      out  1         sticky: a push was dropped
//   underflow     out  1         sticky: a resolve arrived while empty
//   hit_count     out  CNT_W     correct predictions, saturating
//   miss_count    out  CNT_W     mispredictions, saturating
// BEHAVIOUR
//   Reset (async, rst=1): all outputs 0 except empty=1. Pointers, count,
//     counters and sticky flags are cleared immediately, without waiting for clk.
//   Storage: circular buffer of pred_bit; wr_ptr/rd_ptr wrap modulo DEPTH.
//   Push: on a clk edge with enable & pred_valid. Accepted if !full, or if a pop
//     happens in the same cycle. Otherwise it is dropped and overflow is set.
//   Pop: on a clk edge with enable & resolve_valid & !empty. Compares
//     q[rd_ptr] with resolve_taken.
//   Pop while empty: ignored, underflow is set, no pulses. There is no same-cycle
//     bypass from push to pop.
//   Latency: upd_result/upd_taken/mispredict are registered and are valid on the
//     edge after the resolve cycle. Each is high for exactly 1 cycle per pop.
//     upd_taken = resolve_taken. mispredict = (q[rd_ptr] != resolve_taken).
//   Counters: each pop increments exactly one of hit_count or miss_count.
//     Both saturate at 2**CNT_W-1; no wrap.
//   Flush: a mispredicting pop also discards every younger entry.
//     After that edge, count=0 and wr_ptr=rd_ptr. A push in the same cycle is
//     discarded and does NOT set overflow.
//   Simultaneous push and pop (no mispredict): count is unchanged and both
//     pointers advance.
//   enable=0: state holds and pulse outputs are 0. Sticky flags clear only on rst.
//   Reset mid-operation: all queued entries are lost. No pulse is emitted for them.
// TESTING
//   1. rst pulse mid-cycle -> empty=1, count=0 and all counters 0 before the next clk edge.
//   2. Push 1,1,0 (DEPTH=4); resolve 1,1,0 -> three upd_result pulses,
//      mispredict never set, hit_count=3, empty=1.
//   3. Push 1,0,1; resolve 0 -> mispredict pulse, upd_taken=0, count=0,
//      miss_count=1; the next resolve sets underflow.
//   4. Push 5 while DEPTH=4 -> full=1, overflow=1, count=4.
//      Then simultaneous push+resolve (correct) -> count stays 4, overflow unchanged.
//   5. Fill, then drain, 3 times (pointer wrap) -> FIFO order is preserved for
//      pattern 1,0,0,1.
//   6. CNT_W=2, 5 correct resolves -> hit_count stays at 3.
//      enable=0 with valid inputs -> no state change.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branch directions. Each resolve is paired with the
// oldest entry, trains the predictor, flags mispredictions and keeps hit/miss counts.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     pred_valid,
  input  logic                     pred_bit,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     upd_result,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count
);

  // Handshake: pred_valid and resolve_valid are single-cycle requests with no
  // ready; a push is taken only when there is room (or a pop frees a slot), and
  // a resolve is taken only when an entry exists.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] q_q, q_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic             upd_result_q, upd_result_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;

  logic is_full, is_empty, do_pop, do_push, push_req, mis;

  always_comb begin
    is_full  = (count_q == DEPTH_C);
    is_empty = (count_q == '0);
    push_req = enable & pred_valid;
    do_pop   = enable & resolve_valid & ~is_empty;
    mis      = do_pop & (q_q[rd_ptr_q] != resolve_taken);
    // A mispredict flushes the wrong path, so a same-cycle push is wrong-path too.
    do_push  = push_req & (~is_full | do_pop) & ~mis;

    q_d          = q_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(do_push) - CW'(do_pop);
    overflow_d   = overflow_q | (push_req & is_full & ~do_pop);
    underflow_d  = underflow_q | (enable & resolve_valid & is_empty);
    hit_d        = hit_q;
    miss_d       = miss_q;
    upd_result_d = do_pop;
    upd_taken_d  = do_pop & resolve_taken;
    mispredict_d = mis;

    if (do_push) begin
      q_d[wr_ptr_q] = pred_bit;
      wr_ptr_d      = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (mis) begin
      wr_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = '0;
    end

    if (do_pop && !mis && hit_q != CNT_MAX) begin
      hit_d = hit_q + CNT_ONE;
    end
    if (mis && miss_q != CNT_MAX) begin
      miss_d = miss_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q          <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
      upd_result_q <= 1'b0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      upd_result_q <= upd_result_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign upd_result = upd_result_q;
  assign upd_taken  = upd_taken_q;
  assign mispredict = mispredict_q;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule
